// File: rtl/branch_predictor_if.sv
// Bus between the core and the branch direction predictor.
// master: the core side (fetch/EX drive PC and resolve data, receive
// prediction and redirect). slave: the predictor itself.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_stall;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            ex_branch_taken;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output f_pc, ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target,
               ex_pred_taken, ex_branch_taken,
        input  f_pred_taken, redirect_valid, redirect_pc
    );

    modport slave (
        input  f_pc, ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target,
               ex_pred_taken, ex_branch_taken,
        output f_pred_taken, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Branch direction predictor with mispredict resolver.
// Table of 2-bit saturating counters indexed by pc[IDX_W+1:2]; fetch reads
// it combinationally, EX trains it and raises a registered one-cycle
// redirect on a mispredict. While a redirect is out, the EX instruction is
// wrong-path and is ignored.
// Optional feature macro: BP_STATS_EN adds saturating resolve/mispredict
// counters (stat_branches, stat_mispredicts).
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      r_bht [BHT_ENTRIES];
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_res;
    logic             w_mis;
    logic [1:0]       w_ctr_next;
    logic [XLEN-1:0]  w_redirect_pc_next;
    logic             w_unused_bits;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
            else              nxt = ctr;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
            else              nxt = ctr;
        end
        return nxt;
    endfunction

    assign w_f_idx  = bp.f_pc[IDX_W+1:2];
    assign w_ex_idx = bp.ex_pc[IDX_W+1:2];

    // PC low bits and fetch PC bits above the index never select anything.
    assign w_unused_bits = ^{bp.f_pc[1:0], bp.f_pc[XLEN-1:IDX_W+2]};

    // Resolve/mispredict qualification and next-state values for table and redirect.
    always_comb begin
        w_res              = 1'b0;
        w_mis              = 1'b0;
        w_ctr_next         = r_bht[w_ex_idx];
        w_redirect_pc_next = r_redirect_pc;
        w_res = bp.ex_valid & bp.ex_is_branch & ~bp.ex_stall & ~r_redirect_valid;
        w_mis = w_res & (bp.ex_branch_taken != bp.ex_pred_taken);
        w_ctr_next = ctr_step(r_bht[w_ex_idx], bp.ex_branch_taken);
        if (bp.ex_branch_taken) begin
            w_redirect_pc_next = bp.ex_target;
        end else begin
            w_redirect_pc_next = bp.ex_pc + XLEN'(4);
        end
    end

    // Counter table: reset to weakly not-taken, train the EX entry on resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_res) begin
            r_bht[w_ex_idx] <= w_ctr_next;
        end
    end

    // Redirect register: one-cycle pulse after a mispredict; PC holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_mis;
            if (w_mis) begin
                r_redirect_pc <= w_redirect_pc_next;
            end
        end
    end

    assign bp.f_pred_taken   = r_bht[w_f_idx][1];
    assign bp.redirect_valid = r_redirect_valid;
    assign bp.redirect_pc    = r_redirect_pc;

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Saturating event counters for resolved branches and mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (w_res && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mis && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (BHT_ENTRIES=64,
// index = pc[7:2]). Inputs change 1 time unit after the rising edge;
// outputs are checked in the same window.
module tb_branch_predictor;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    branch_predictor_if #(.XLEN(32)) bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.XLEN(32), .BHT_ENTRIES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus.slave)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic st,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pred, input logic tkn);
        bus.ex_valid        = v;
        bus.ex_is_branch    = br;
        bus.ex_stall        = st;
        bus.ex_pc           = pc;
        bus.ex_target       = tgt;
        bus.ex_pred_taken   = pred;
        bus.ex_branch_taken = tkn;
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
        bus.f_pc = pc;
        #1;
        check_eq(tag, {31'd0, bus.f_pred_taken}, {31'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b0;
        bus.f_pc = 32'h0;
        idle();
        step();

        // Reset state
        do_reset();
        check_eq("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
        check_eq("rst_rpc", bus.redirect_pc, 32'h0);
        check_pred("rst_pred_100", 32'h100, 1'b0);

        // Taken mispredict at 0x100; same-cycle lookup sees old value
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1);
        check_pred("nobypass_100", 32'h100, 1'b0);
        step();
        idle();
        check_eq("mis1_rv", {31'd0, bus.redirect_valid}, 32'd1);
        check_eq("mis1_rpc", bus.redirect_pc, 32'h80);
        check_pred("mis1_pred", 32'h100, 1'b1);
        step();
        check_eq("mis1_pulse_end", {31'd0, bus.redirect_valid}, 32'd0);

        // Three correct taken trains: 10 -> 11 -> 11 -> 11, no redirects
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b1);
            step();
            check_eq("sat_rv", {31'd0, bus.redirect_valid}, 32'd0);
        end
        idle();
        check_pred("sat_pred", 32'h100, 1'b1);
        // Not-taken, predicted taken: 11 -> 10, redirect to fall-through
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0);
        step();
        idle();
        check_eq("nt_rv", {31'd0, bus.redirect_valid}, 32'd1);
        check_eq("nt_rpc", bus.redirect_pc, 32'h104);
        check_pred("nt_pred_still1", 32'h100, 1'b1);
        step();
        // Correct not-taken: 10 -> 01
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b0);
        step();
        idle();
        check_eq("nt2_rv", {31'd0, bus.redirect_valid}, 32'd0);
        check_pred("nt2_pred", 32'h100, 1'b0);

        // Wrong-path: branch in redirect cycle neither redirects nor trains
        do_reset();
        drive_ex(1'b1, 1'b1, 1'b0, 32'h200, 32'h400, 1'b0, 1'b1);
        step();
        drive_ex(1'b1, 1'b1, 1'b0, 32'h300, 32'h500, 1'b0, 1'b1);
        check_eq("wp_rv", {31'd0, bus.redirect_valid}, 32'd1);
        check_eq("wp_rpc", bus.redirect_pc, 32'h400);
        step();
        idle();
        check_eq("wp_no2nd", {31'd0, bus.redirect_valid}, 32'd0);
        check_eq("wp_rpc_hold", bus.redirect_pc, 32'h400);
        // idx0 should be 10; correct not-taken brings it to 01 (11 -> 10 if 0x300 trained)
        drive_ex(1'b1, 1'b1, 1'b0, 32'h300, 32'h500, 1'b0, 1'b0);
        step();
        idle();
        check_pred("wp_notrain", 32'h300, 1'b0);

        // Non-branch and bubble leave everything alone
        do_reset();
        drive_ex(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1);
        step();
        check_eq("nonbr_rv", {31'd0, bus.redirect_valid}, 32'd0);
        drive_ex(1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1);
        step();
        idle();
        check_eq("bubble_rv", {31'd0, bus.redirect_valid}, 32'd0);
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b1);
        step();
        idle();
        check_pred("nonbr_notrain", 32'h100, 1'b1);
        check_eq("nonbr_rpc", bus.redirect_pc, 32'h0);

        // Stall for three cycles then release
        do_reset();
        drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_rv", {31'd0, bus.redirect_valid}, 32'd0);
            check_pred("stall_pred", 32'h100, 1'b0);
        end
        bus.ex_stall = 1'b0;
        step();
        idle();
        check_eq("unstall_rv", {31'd0, bus.redirect_valid}, 32'd1);
        check_eq("unstall_rpc", bus.redirect_pc, 32'h80);
        check_pred("unstall_pred", 32'h100, 1'b1);
        step();
        check_eq("unstall_end", {31'd0, bus.redirect_valid}, 32'd0);
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b0);
        step();
        idle();
        check_pred("stall_once", 32'h100, 1'b0);

        // PC+4 wraps at top of address space
        do_reset();
        drive_ex(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0);
        step();
        idle();
        check_eq("wrap_rv", {31'd0, bus.redirect_valid}, 32'd1);
        check_eq("wrap_rpc", bus.redirect_pc, 32'h0);
        step();

        // Aliasing: 0x104 and 0x104 + 4*64 share a counter
        drive_ex(1'b1, 1'b1, 1'b0, 32'h104, 32'h80, 1'b1, 1'b1);
        step();
        idle();
        check_eq("alias_rv", {31'd0, bus.redirect_valid}, 32'd0);
        check_pred("alias_204", 32'h204, 1'b1);
        check_pred("alias_104", 32'h104, 1'b1);
        check_pred("alias_nbr", 32'h108, 1'b0);

        // Mid-run reset with a redirect out and a mispredict in EX
        drive_ex(1'b1, 1'b1, 1'b0, 32'h10C, 32'h900, 1'b0, 1'b1);
        step();
        check_eq("pre_rst_rv", {31'd0, bus.redirect_valid}, 32'd1);
        drive_ex(1'b1, 1'b1, 1'b0, 32'h110, 32'hA00, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check_eq("midrst_rv", {31'd0, bus.redirect_valid}, 32'd0);
        check_eq("midrst_rpc", bus.redirect_pc, 32'h0);
        for (int i = 0; i < 64; i++) begin
            check_pred("midrst_idx", i * 4, 1'b0);
        end
        step();
        check_eq("midrst_after", {31'd0, bus.redirect_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Direction predictor and mispredict resolver for the 5-stage core. The fetch side reads a table of 2-bit saturating counters to get a predicted taken bit. The EX side takes the resolved branch condition (the beq/bne/blt/bge/bltu/bgeu outcome), trains the table and issues a registered PC redirect/flush when the prediction was wrong. The fetch pre-decoder computes branch targets; this block supplies direction only.

Parameters:
XLEN, 32, address/PC width
BHT_ENTRIES, 64, counter table depth; power of 2, min 2
IDX_W, log2(BHT_ENTRIES), localparam, table index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
f_pc  input  XLEN  PC of instruction in fetch
f_pred_taken  output  1  predicted direction for f_pc (combinational read of registered table)
ex_valid  input  1  EX stage holds a real instruction
ex_is_branch  input  1  EX instruction is a conditional branch
ex_stall  input  1  EX stage frozen this cycle
ex_pc  input  XLEN  PC of EX instruction
ex_target  input  XLEN  computed branch target
ex_pred_taken  input  1  prediction carried down the pipe with this instruction
ex_branch_taken  input  1  resolved branch condition
redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc, flush IF/ID
redirect_pc  output  XLEN  correct next PC

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): every counter set to 2'b01 (weakly not-taken); redirect_valid=0; redirect_pc=0. Applies mid-operation. Any pending redirect is dropped. The EX inputs that cycle are ignored.
- Index: idx = pc[IDX_W+1:2]. Bits [1:0] are ignored.
- Lookup: f_pred_taken = counter[f_pc idx][1]. Combinational, no latency.
- Resolve cycle: res = ex_valid & ex_is_branch & ~ex_stall & ~redirect_valid.
- Wrong-path rule: while redirect_valid=1, the instruction in EX is wrong-path. It trains nothing and redirects nothing.
- Training (at the clk edge when res=1), counter at ex_pc idx:
  - if ex_branch_taken: increment, saturating at 2'b11.
  - else: decrement, saturating at 2'b00.
- Mispredict: mis = res & (ex_branch_taken != ex_pred_taken).
- Redirect is registered. In the next cycle redirect_valid=1 and redirect_pc is:
  - ex_target when ex_branch_taken=1,
  - else ex_pc+4 (mod 2^XLEN, wraps at top of address space).
- Otherwise redirect_valid=0. redirect_pc holds its last value; it is don't-care when valid=0.
- Latency: one cycle from resolve to redirect pulse. The pulse is always exactly one cycle wide. Two consecutive mispredicts cannot both pulse because of the wrong-path rule.
- Same-cycle lookup and train on the same index: lookup returns the pre-update value (no bypass). The new value is visible the following cycle.
- ex_stall=1: no training, no redirect. The EX instruction is resolved in the first unstalled cycle.
- Non-branch (ex_is_branch=0) or bubble (ex_valid=0): table and redirect untouched.

Optional Feature:
BP_STATS_EN
- Defined: adds two outputs, stat_branches and stat_mispredicts, 32 bits each.
  - stat_branches increments on every res cycle.
  - stat_mispredicts increments on every mis cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Not defined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then f_pc=0x100 -> f_pred_taken=0. All indices read 0 after a mid-run rst.
- ex_pc=0x100, pred 0, taken 1, target 0x80 -> next cycle redirect_valid=1, redirect_pc=0x80. Counter goes 01->10, and f_pc=0x100 then predicts 1.
- Three taken trains at 0x100, then one not-taken -> counter 11 (saturates), then 10; prediction still 1, and the not-taken resolve causes a redirect to 0x104.
- Mispredict at 0x200, then valid branch at 0x300 in the redirect cycle -> no second pulse and no training at 0x300 idx.
- ex_stall=1 with a mispredicting branch for 3 cycles, then 0 -> single redirect one cycle after stall drops; counter trained once.
- ex_pc=0xFFFF_FFFC, not-taken, predicted taken -> redirect_pc=0x0000_0000. Indices 0x104 and 0x104+4*BHT_ENTRIES alias to the same counter.
